// File: rtl/eth_rx_ring_pkg.sv
// Shared definitions for the Ethernet receive ring: register map,
// receive FSM states and frame-format constants.
package eth_rx_pkg;

    // Register offsets relative to REG_BASE
    localparam logic [2:0] REG_CR     = 3'd0;
    localparam logic [2:0] REG_COUNT  = 3'd1;
    localparam logic [2:0] REG_LEN_LO = 3'd2;
    localparam logic [2:0] REG_LEN_HI = 3'd3;
    localparam logic [2:0] REG_DROP   = 3'd4;
    localparam int         REG_NUM    = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DISCARD = 2'd2
    } rx_state_t;

    localparam logic [47:0] MAC_BCAST     = 48'hff_ff_ff_ff_ff_ff;
    localparam int          MIN_FRAME_LEN = 6;

    // Byte idx of a MAC address in wire order (byte 0 is sent first).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            3'd5:    b = mac[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/eth_rx_ring_if.sv
// Receive link and CPU bus signals of the Ethernet receive ring.
interface eth_rx_ring_if;
    logic        recv_sck;
    logic        recv_mosi;
    logic        n_recv_ss;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        n_we;
    logic        n_oe;

    modport master (
        output recv_sck, recv_mosi, n_recv_ss, a, d_in, n_we, n_oe,
        input  d_out, d_oe
    );

    modport slave (
        input  recv_sck, recv_mosi, n_recv_ss, a, d_in, n_we, n_oe,
        output d_out, d_oe
    );
endinterface

// File: rtl/eth_rx_ring_slot_ram.sv
// Frame storage: NUM_SLOTS x 2^ADDR_W bytes, one synchronous write port
// (receiver) and one synchronous read port (CPU window), addressed {slot, offset}.
module eth_rx_slot_ram
    import eth_rx_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int ADDR_W    = 11
) (
    input  logic                                  clk,
    input  logic                                  we,
    input  logic [$clog2(NUM_SLOTS)+ADDR_W-1:0]   waddr,
    input  logic [7:0]                            wdata,
    input  logic [$clog2(NUM_SLOTS)+ADDR_W-1:0]   raddr,
    output logic [7:0]                            rdata
);
    localparam int DEPTH = NUM_SLOTS << ADDR_W;

    logic [7:0] mem [DEPTH];

    // Write port: one received byte per strobe
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered read for the CPU window
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/eth_rx_ring.sv
// Ethernet frame receiver: deserialises link frames into a ring of slots,
// filters on destination MAC and exposes the head slot to the CPU.
module eth_rx_ring
    import eth_rx_pkg::*;
#(
    parameter int          NUM_SLOTS     = 4,
    parameter int          ADDR_W        = 11,
    parameter logic [15:0] REG_BASE      = 16'hfb00,
    parameter logic [15:0] BUF_BASE      = 16'hf000,
    parameter bit          MAC_FILTER_EN = 1'b1,
    parameter logic [47:0] MAC_ADDR      = 48'h02_00_00_00_00_01
) (
    input logic         clk,
    input logic         rst,
    eth_rx_ring_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = PTR_W + 1;
    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] SLOT_BYTES = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LEN_W-1:0] MIN_LEN    = LEN_W'(MIN_FRAME_LEN);
    localparam logic [CNT_W-1:0] SLOTS_C    = CNT_W'(NUM_SLOTS);

    // Link synchronisers; third stage holds the previous value for edge detection
    logic [2:0] sck_sr;
    logic [1:0] mosi_sr;
    logic [2:0] ss_sr;
    logic       sck_rise, ss_fall, ss_rise, ss_low, mosi_s;

    // Receive state
    rx_state_t              state, state_n;
    logic [2:0]             bit_cnt;
    logic [6:0]             shreg;
    logic [LEN_W-1:0]       byte_cnt;
    logic                   ucast_ok, bcast_ok;
    logic [7:0]             rx_byte;
    logic                   byte_done, in_hdr, u_next, b_next, filter_reject;
    logic                   start_rx, drop_inc, shift_en, commit;

    // Slot RAM write stage
    logic                   wr_en_q;
    logic [PTR_W+ADDR_W-1:0] wr_addr_q;
    logic [7:0]             wr_data_q;

    // Ring bookkeeping
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [LEN_W-1:0]       len [NUM_SLOTS];
    logic [7:0]             drop_cnt;
    logic                   full, avail;
    logic [LEN_W-1:0]       head_len;
    logic [15:0]            head_len16;

    // CPU bus
    logic                   we_q, we_fall;
    logic [15:0]            reg_off;
    logic                   reg_hit, win_hit;
    logic                   pop, drop_clr;
    logic [7:0]             reg_rdata;
    logic [7:0]             reg_q;
    logic                   win_sel_q;
    logic [7:0]             ram_rdata;
    logic                   unused_d_in;

    assign unused_d_in = ^bus.d_in[7:1];

    // Synchronise link pins into clk; reset assumes a frame in progress so a
    // frame already running at reset release is discarded rather than captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sr  <= '0;
            mosi_sr <= '0;
            ss_sr   <= '0;
        end else begin
            sck_sr  <= {sck_sr[1:0], bus.recv_sck};
            mosi_sr <= {mosi_sr[0], bus.recv_mosi};
            ss_sr   <= {ss_sr[1:0], bus.n_recv_ss};
        end
    end

    assign sck_rise = sck_sr[1] & ~sck_sr[2];
    assign ss_fall  = ~ss_sr[1] & ss_sr[2];
    assign ss_rise  = ss_sr[1] & ~ss_sr[2];
    assign ss_low   = ~ss_sr[1] & ~ss_sr[2];
    assign mosi_s   = mosi_sr[1];

    assign full  = (count == SLOTS_C);
    assign avail = (count != '0);

    // Header filter: a byte in the first six must keep unicast or broadcast alive
    always_comb begin
        rx_byte       = {shreg, mosi_s};
        byte_done     = shift_en & (bit_cnt == 3'd7);
        in_hdr        = (byte_cnt < MIN_LEN);
        u_next        = ucast_ok & (rx_byte == mac_byte(MAC_ADDR, byte_cnt[2:0]));
        b_next        = bcast_ok & (rx_byte == mac_byte(MAC_BCAST, byte_cnt[2:0]));
        filter_reject = MAC_FILTER_EN & byte_done & in_hdr & ~u_next & ~b_next;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state; envelope low in IDLE without a falling edge only happens
    // after reset, and that frame is thrown away
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_n = full ? ST_DISCARD : ST_RECV;
                end else if (ss_low) begin
                    state_n = ST_DISCARD;
                end
            end
            ST_RECV: begin
                if (ss_rise) begin
                    state_n = ST_IDLE;
                end else if (filter_reject) begin
                    state_n = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (ss_rise) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM outputs: per-cycle strobes for the receive datapath and ring
    always_comb begin
        start_rx = 1'b0;
        drop_inc = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        case (state)
            ST_IDLE: begin
                start_rx = ss_fall & ~full;
                drop_inc = ss_fall & full;
            end
            ST_RECV: begin
                shift_en = sck_rise & ~ss_rise;
                commit   = ss_rise & (byte_cnt >= MIN_LEN);
            end
            default: ;
        endcase
    end

    // Receive counters and filter flags; bytes past the slot end are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            ucast_ok <= 1'b1;
            bcast_ok <= 1'b1;
            wr_en_q  <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (start_rx) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
                ucast_ok <= 1'b1;
                bcast_ok <= 1'b1;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    if (in_hdr) begin
                        ucast_ok <= u_next;
                        bcast_ok <= b_next;
                    end
                    if (byte_cnt != SLOT_BYTES) begin
                        wr_en_q  <= 1'b1;
                        byte_cnt <= byte_cnt + LEN_W'(1);
                    end
                end
            end
        end
    end

    // Shift register and RAM write data (no reset: pure data)
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shreg <= rx_byte[6:0];
        end
        if (byte_done) begin
            wr_data_q <= rx_byte;
            wr_addr_q <= {wr_ptr, byte_cnt[ADDR_W-1:0]};
        end
    end

    // CPU write strobe edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q <= 1'b1;
        end else begin
            we_q <= bus.n_we;
        end
    end

    assign we_fall  = we_q & ~bus.n_we;
    assign reg_off  = bus.a - REG_BASE;
    assign reg_hit  = (bus.a >= REG_BASE) && (reg_off < 16'(REG_NUM));
    assign win_hit  = (bus.a[15:ADDR_W] == BUF_BASE[15:ADDR_W]);
    assign pop      = we_fall & reg_hit & (reg_off[2:0] == REG_CR) & bus.d_in[0] & avail;
    assign drop_clr = we_fall & reg_hit & (reg_off[2:0] == REG_DROP);

    // Ring pointers, occupancy, slot lengths and drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                len[i] <= '0;
            end
        end else begin
            if (commit) begin
                wr_ptr      <= wr_ptr + PTR_W'(1);
                len[wr_ptr] <= byte_cnt;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({commit, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            if (drop_clr) begin
                drop_cnt <= '0;
            end else if (drop_inc && drop_cnt != 8'hff) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign head_len   = avail ? len[rd_ptr] : '0;
    assign head_len16 = 16'(head_len);

    // Register read multiplexer
    always_comb begin
        reg_rdata = 8'h00;
        case (reg_off[2:0])
            REG_CR:     reg_rdata = {6'b0, full, avail};
            REG_COUNT:  reg_rdata = 8'(count);
            REG_LEN_LO: reg_rdata = head_len16[7:0];
            REG_LEN_HI: reg_rdata = head_len16[15:8];
            REG_DROP:   reg_rdata = drop_cnt;
            default:    reg_rdata = 8'h00;
        endcase
    end

    // Read data stage: register value or window select, zero when unselected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q     <= '0;
            win_sel_q <= 1'b0;
        end else begin
            win_sel_q <= ~bus.n_oe & win_hit & ~reg_hit;
            reg_q     <= (~bus.n_oe & reg_hit) ? reg_rdata : 8'h00;
        end
    end

    eth_rx_slot_ram #(
        .NUM_SLOTS (NUM_SLOTS),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en_q),
        .waddr (wr_addr_q),
        .wdata (wr_data_q),
        .raddr ({rd_ptr, bus.a[ADDR_W-1:0]}),
        .rdata (ram_rdata)
    );

    assign bus.d_out = win_sel_q ? ram_rdata : reg_q;
    assign bus.d_oe  = ~bus.n_oe & (reg_hit | win_hit);

endmodule

// File: tb/tb_eth_rx_ring.sv
// Directed bench for eth_rx_ring: register/window expectations held in a
// phase-tagged table, plus hand-written sequences for multi-cycle cases.
module tb_eth_rx_ring;
    import eth_rx_pkg::*;

    localparam int          AW    = 8;
    localparam logic [15:0] RB    = 16'hfb00;
    localparam logic [15:0] BB    = 16'hf000;
    localparam logic [47:0] STA   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_99;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_rx_ring_if bus_if();

    eth_rx_ring #(
        .NUM_SLOTS     (4),
        .ADDR_W        (AW),
        .REG_BASE      (RB),
        .BUF_BASE      (BB),
        .MAC_FILTER_EN (1'b1),
        .MAC_ADDR      (STA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    typedef struct {
        int          phase;
        logic [15:0] addr;
        logic [7:0]  exp_d;
        logic        exp_oe;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic logic [15:0] ra(input logic [2:0] off);
        return RB + 16'(off);
    endfunction

    function automatic logic [15:0] wa(input int off);
        return BB + 16'(off);
    endfunction

    // Frame content: destination MAC then an index-derived pattern
    function automatic logic [7:0] fbyte(input logic [47:0] dst, input int i);
        logic [47:0] m;
        m = dst;
        if (i < 6) return m[47-8*i -: 8];
        return 8'(i * 7 + 3);
    endfunction

    task automatic add(input int p, input logic [15:0] addr, input logic [7:0] d,
                       input logic oe, input string name);
        vec_t v;
        v.phase = p; v.addr = addr; v.exp_d = d; v.exp_oe = oe; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic cpu_read(input logic [15:0] addr, output logic [7:0] d, output logic oe);
        bus_if.a    = addr;
        bus_if.n_oe = 1'b0;
        tick(1);
        d  = bus_if.d_out;
        oe = bus_if.d_oe;
        tick(1);
        bus_if.n_oe = 1'b1;
        tick(1);
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] d);
        bus_if.a    = addr;
        bus_if.d_in = d;
        bus_if.n_we = 1'b0;
        tick(2);
        bus_if.n_we = 1'b1;
        tick(1);
    endtask

    task automatic send_bit(input logic b);
        bus_if.recv_mosi = b;
        bus_if.recv_sck  = 1'b0;
        tick(3);
        bus_if.recv_sck  = 1'b1;
        tick(3);
    endtask

    task automatic send_byte(input logic [7:0] x);
        for (int i = 7; i >= 0; i--) send_bit(x[i]);
    endtask

    // Whole frame; optionally issues a CR pop timed to land with the commit
    task automatic send_frame(input logic [47:0] dst, input int n, input bit pop_at_end);
        bus_if.n_recv_ss = 1'b0;
        tick(4);
        for (int i = 0; i < n; i++) send_byte(fbyte(dst, i));
        tick(3);
        bus_if.n_recv_ss = 1'b1;
        if (pop_at_end) begin
            tick(2);
            bus_if.a    = ra(REG_CR);
            bus_if.d_in = 8'h01;
            bus_if.n_we = 1'b0;
            tick(2);
            bus_if.n_we = 1'b1;
            tick(4);
        end else begin
            tick(6);
        end
    endtask

    task automatic run_phase(input int p);
        logic [7:0] d;
        logic       oe;
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) begin
                cpu_read(vecs[i].addr, d, oe);
                check8($sformatf("p%0d %s data", p, vecs[i].name), d, vecs[i].exp_d);
                check8($sformatf("p%0d %s d_oe", p, vecs[i].name), {7'b0, oe}, {7'b0, vecs[i].exp_oe});
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       oe;

        // Reset state and decode boundaries
        add(0, ra(REG_CR),     8'h00, 1'b1, "reset CR");
        add(0, ra(REG_COUNT),  8'h00, 1'b1, "reset COUNT");
        add(0, ra(REG_LEN_LO), 8'h00, 1'b1, "reset LEN_LO");
        add(0, ra(REG_LEN_HI), 8'h00, 1'b1, "reset LEN_HI");
        add(0, ra(REG_DROP),   8'h00, 1'b1, "reset DROP");
        add(0, RB + 16'd5,     8'h00, 1'b0, "past reg block");
        add(0, 16'h1234,       8'h00, 1'b0, "unmapped");
        // Single 64-byte unicast frame
        add(1, ra(REG_CR),     8'h01, 1'b1, "single CR");
        add(1, ra(REG_COUNT),  8'h01, 1'b1, "single COUNT");
        add(1, ra(REG_LEN_LO), 8'h40, 1'b1, "single LEN_LO");
        add(1, ra(REG_LEN_HI), 8'h00, 1'b1, "single LEN_HI");
        add(1, wa(0),  fbyte(STA, 0),  1'b1, "single win0");
        add(1, wa(6),  fbyte(STA, 6),  1'b1, "single win6");
        add(1, wa(63), fbyte(STA, 63), 1'b1, "single win63");
        // After pop
        add(2, ra(REG_CR),     8'h00, 1'b1, "popped CR");
        add(2, ra(REG_COUNT),  8'h00, 1'b1, "popped COUNT");
        add(2, ra(REG_LEN_LO), 8'h00, 1'b1, "popped LEN_LO");
        // Filter reject
        add(3, ra(REG_COUNT),  8'h00, 1'b1, "filtered COUNT");
        add(3, ra(REG_DROP),   8'h00, 1'b1, "filtered DROP");
        // Broadcast accepted
        add(4, ra(REG_COUNT),  8'h01, 1'b1, "bcast COUNT");
        add(4, ra(REG_LEN_LO), 8'h14, 1'b1, "bcast LEN_LO");
        add(4, wa(0),          8'hff, 1'b1, "bcast win0");
        // Overflow
        add(5, ra(REG_COUNT),  8'h04, 1'b1, "ovf COUNT");
        add(5, ra(REG_CR),     8'h03, 1'b1, "ovf CR");
        add(5, ra(REG_DROP),   8'h01, 1'b1, "ovf DROP");
        add(6, ra(REG_CR),     8'h00, 1'b1, "drained CR");
        add(6, ra(REG_DROP),   8'h01, 1'b1, "drained DROP");
        add(7, ra(REG_DROP),   8'h00, 1'b1, "cleared DROP");
        add(7, ra(REG_COUNT),  8'h00, 1'b1, "empty pop COUNT");
        // Slot saturation (256-byte slots)
        add(8, ra(REG_COUNT),  8'h01, 1'b1, "sat COUNT");
        add(8, ra(REG_LEN_LO), 8'h00, 1'b1, "sat LEN_LO");
        add(8, ra(REG_LEN_HI), 8'h01, 1'b1, "sat LEN_HI");
        add(8, wa(255), fbyte(STA, 255), 1'b1, "sat win255");
        // Runt and minimum-length frames
        add(9, ra(REG_COUNT),  8'h00, 1'b1, "runt COUNT");
        add(9, ra(REG_CR),     8'h00, 1'b1, "runt CR");
        add(10, ra(REG_COUNT), 8'h01, 1'b1, "min COUNT");
        add(10, ra(REG_LEN_LO), 8'h06, 1'b1, "min LEN_LO");
        // Commit and pop together
        add(11, ra(REG_COUNT), 8'h01, 1'b1, "concur COUNT");
        add(11, ra(REG_LEN_LO), 8'h18, 1'b1, "concur LEN_LO");
        // Reset mid-frame
        add(12, ra(REG_COUNT), 8'h00, 1'b1, "midrst COUNT");
        add(12, ra(REG_CR),    8'h00, 1'b1, "midrst CR");
        add(13, ra(REG_COUNT), 8'h01, 1'b1, "after COUNT");
        add(13, ra(REG_LEN_LO), 8'h1e, 1'b1, "after LEN_LO");
        add(13, wa(6),  fbyte(STA, 6),  1'b1, "after win6");
        add(13, wa(29), fbyte(STA, 29), 1'b1, "after win29");

        bus_if.recv_sck  = 1'b0;
        bus_if.recv_mosi = 1'b0;
        bus_if.n_recv_ss = 1'b1;
        bus_if.a         = 16'h0000;
        bus_if.d_in      = 8'h00;
        bus_if.n_we      = 1'b1;
        bus_if.n_oe      = 1'b1;
        rst = 1'b1;
        tick(3);
        check8("reset d_out", bus_if.d_out, 8'h00);
        check8("reset d_oe", {7'b0, bus_if.d_oe}, 8'h00);
        rst = 1'b0;
        tick(6);
        run_phase(0);

        send_frame(STA, 64, 1'b0);
        run_phase(1);
        cpu_write(ra(REG_CR), 8'h01);
        run_phase(2);

        send_frame(OTHER, 12, 1'b0);
        run_phase(3);
        send_frame(MAC_BCAST, 20, 1'b0);
        run_phase(4);
        cpu_write(ra(REG_CR), 8'h01);

        for (int k = 0; k < 5; k++) send_frame(STA, 10 + k, 1'b0);
        run_phase(5);
        for (int k = 0; k < 4; k++) begin
            cpu_read(ra(REG_LEN_LO), d, oe);
            check8($sformatf("fifo len %0d", k), d, 8'(10 + k));
            cpu_write(ra(REG_CR), 8'h01);
        end
        run_phase(6);
        cpu_write(ra(REG_DROP), 8'h5a);
        cpu_write(ra(REG_CR), 8'h01);
        run_phase(7);

        send_frame(STA, 270, 1'b0);
        run_phase(8);
        cpu_write(ra(REG_CR), 8'h01);

        send_frame(STA, 5, 1'b0);
        run_phase(9);
        send_frame(STA, 6, 1'b0);
        run_phase(10);
        cpu_write(ra(REG_CR), 8'h01);

        send_frame(STA, 16, 1'b0);
        send_frame(STA, 24, 1'b1);
        run_phase(11);

        // Reset in the middle of a frame, then let the frame finish
        bus_if.n_recv_ss = 1'b0;
        tick(4);
        for (int i = 0; i < 3; i++) send_byte(fbyte(STA, i));
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int i = 3; i < 20; i++) send_byte(fbyte(STA, i));
        tick(3);
        bus_if.n_recv_ss = 1'b1;
        tick(6);
        run_phase(12);

        send_frame(STA, 30, 1'b0);
        run_phase(13);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
